// File: rtl/fb_count_gen_pkg.sv
// Shared constants and helpers for the feedback counter / gray frame slice.
package fb_count_gen_pkg;

    localparam int unsigned CNT_W_DEF    = 16;
    localparam int unsigned GRAY_W_DEF   = 19;
    localparam int unsigned CCLK_DIV_DEF = 16;
    localparam int unsigned TAP_W        = 10;

    typedef logic [TAP_W-1:0] tap_t;

    // The gray selector expects the counter MSB on bit 0.
    function automatic tap_t tap_reverse(input tap_t v);
        tap_t r;
        for (int unsigned i = 0; i < TAP_W; i++) begin
            r[i] = v[TAP_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fb_count_gen_gray_frame.sv
// Free-running binary frame counter with a registered gray image and a frame strobe.
module fb_gray_frame
    import fb_count_gen_pkg::*;
#(
    parameter int unsigned GRAY_W = GRAY_W_DEF
) (
    input  logic              clk_ext,
    input  logic              rst_ext,
    output logic [GRAY_W-1:0] gray,
    output logic              frame
);

    logic [GRAY_W-1:0] b_q, b_d;
    logic [GRAY_W-1:0] gray_q, gray_d;
    logic              frame_q, frame_d;

    // Gray is built from the next binary value so gray_q always encodes b_q.
    always_comb begin
        b_d     = b_q + GRAY_W'(1);
        gray_d  = b_d ^ (b_d >> 1);
        frame_d = (b_d == '0);
    end

    always_ff @(posedge clk_ext) begin
        if (rst_ext) begin
            b_q     <= '0;
            gray_q  <= '0;
            frame_q <= 1'b0;
        end else begin
            b_q     <= b_d;
            gray_q  <= gray_d;
            frame_q <= frame_d;
        end
    end

    assign gray  = gray_q;
    assign frame = frame_q;

endmodule

// File: rtl/fb_count_gen.sv
// Prescaled saturating up/down counter whose MSBs are latched once per gray frame.
module fb_count_gen
    import fb_count_gen_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned GRAY_W   = GRAY_W_DEF,
    parameter int unsigned CCLK_DIV = CCLK_DIV_DEF
) (
    input  logic             clk_ext,
    input  logic             rst_ext,
    input  logic             en,
    input  logic             u_d,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic [TAP_W-1:0] gray_clk,
    output logic [TAP_W-1:0] fb_word,
    output logic             frame,
    output logic             sat_hi,
    output logic             sat_lo
);

    localparam int unsigned       PRE_W     = $clog2(CCLK_DIV);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CCLK_DIV - 1);
    localparam logic [GRAY_W-1:0] GRAY_LAST = {1'b1, {(GRAY_W-1){1'b0}}};

    if (GRAY_W < TAP_W + 1) begin : g_bad_gray_w
        $error("fb_count_gen: GRAY_W must be at least 11");
    end
    if (CCLK_DIV < 2) begin : g_bad_div
        $error("fb_count_gen: CCLK_DIV must be at least 2");
    end
    if (CNT_W < TAP_W) begin : g_bad_cnt_w
        $error("fb_count_gen: CNT_W must be at least 10");
    end

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TAP_W-1:0]  fbw_q, fbw_d;
    logic [GRAY_W-1:0] gray;
    logic              tick;
    logic              wrap;

    fb_gray_frame #(
        .GRAY_W (GRAY_W)
    ) u_gray_frame (
        .clk_ext (clk_ext),
        .rst_ext (rst_ext),
        .gray    (gray),
        .frame   (frame)
    );

    // The binary counter is all-ones exactly when its gray image is 100..0.
    assign wrap = (gray == GRAY_LAST);
    assign tick = (pre_q == PRE_LAST);

    always_comb begin
        pre_d = tick ? '0 : pre_q + PRE_W'(1);

        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (tick && en) begin
            if (u_d) begin
                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            end else begin
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            end
        end

        fbw_d = wrap ? tap_reverse(cnt_q[CNT_W-1 -: TAP_W]) : fbw_q;
    end

    always_ff @(posedge clk_ext) begin
        if (rst_ext) begin
            pre_q <= '0;
            cnt_q <= '0;
            fbw_q <= '0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
            fbw_q <= fbw_d;
        end
    end

    assign count    = cnt_q;
    assign fb_word  = fbw_q;
    assign gray_clk = gray[TAP_W:1];
    assign sat_hi   = &cnt_q;
    assign sat_lo   = ~|cnt_q;

endmodule

// File: tb/tb_fb_count_gen.sv
// Self-checking bench for fb_count_gen (CNT_W=16, GRAY_W=11, CCLK_DIV=16).
module tb_fb_count_gen;

    logic        clk_ext = 1'b0;
    logic        rst_ext = 1'b1;
    logic        en = 1'b0;
    logic        u_d = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0000;
    logic [15:0] count;
    logic [9:0]  gray_clk;
    logic [9:0]  fb_word;
    logic        frame;
    logic        sat_hi;
    logic        sat_lo;

    int checks = 0;
    int passes = 0;

    fb_count_gen #(
        .CNT_W    (16),
        .GRAY_W   (11),
        .CCLK_DIV (16)
    ) dut (
        .clk_ext  (clk_ext),
        .rst_ext  (rst_ext),
        .en       (en),
        .u_d      (u_d),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .gray_clk (gray_clk),
        .fb_word  (fb_word),
        .frame    (frame),
        .sat_hi   (sat_hi),
        .sat_lo   (sat_lo)
    );

    always #5 clk_ext = ~clk_ext;

    // Reference model state, advanced once per rising edge.
    int          m_pre = 0;
    int          m_b = 0;
    logic [15:0] m_cnt = '0;
    logic [9:0]  m_fb = '0;
    logic        m_frame = 1'b0;
    logic [63:0] sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic void model_edge();
        bit tick;
        if (rst_ext) begin
            m_pre = 0; m_b = 0; m_cnt = '0; m_fb = '0; m_frame = 1'b0;
        end else begin
            tick = (m_pre == 15);
            if (m_b == 2047)
                for (int i = 0; i < 10; i++) m_fb[i] = m_cnt[15-i];
            if (load) m_cnt = load_val;
            else if (tick && en) begin
                if (u_d && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                else if (!u_d && m_cnt != 16'h0000) m_cnt = m_cnt - 16'd1;
            end
            m_pre = tick ? 0 : m_pre + 1;
            m_b = (m_b + 1) % 2048;
            m_frame = (m_b == 0);
        end
    endfunction

    function automatic logic [63:0] model_word();
        int g;
        logic [9:0] gc;
        g = m_b ^ (m_b >> 1);
        gc = g[10:1];
        return {25'd0, m_cnt, m_fb, m_frame, gc, (m_cnt == 16'hFFFF), (m_cnt == 16'h0000)};
    endfunction

    task automatic step();
        logic [63:0] a, e;
        @(posedge clk_ext);
        model_edge();
        sb.push_back(model_word());
        #1;
        a = {25'd0, count, fb_word, frame, gray_clk, sat_hi, sat_lo};
        if (sb.size() == 0) begin
            checks++;
            $display("FAIL scoreboard: queue empty, got %h", a);
        end else begin
            e = sb.pop_front();
            chk("scoreboard", a, e);
        end
    endtask

    task automatic do_reset();
        rst_ext = 1'b1; load = 1'b0; en = 1'b0;
        step();
        step();
        rst_ext = 1'b0;
    endtask

    typedef struct {
        logic        do_load;
        logic [15:0] lv;
        logic        en;
        logic        ud;
        int          ncyc;
        logic [15:0] exp_cnt;
        logic        exp_hi;
        logic        exp_lo;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int frames[$];
        int ham_bad;
        int frame_at;
        int tick_at;
        logic [9:0] prev_gc;

        //          load  lv        en    ud    n    count     hi    lo
        vecs[0] = '{1'b0, 16'h0000, 1'b1, 1'b1, 160, 16'h000A, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 16'hFFFE, 1'b1, 1'b1, 64,  16'hFFFF, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 16'h0001, 1'b1, 1'b0, 48,  16'h0000, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 16'h1234, 1'b0, 1'b1, 64,  16'h1234, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 16'h8000, 1'b1, 1'b1, 47,  16'h8003, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 16'h0005, 1'b1, 1'b0, 31,  16'h0003, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 16'h0000, 1'b1, 1'b0, 40,  16'h0000, 1'b0, 1'b1};

        // Reset overrides a simultaneous load and enable.
        rst_ext = 1'b1; load = 1'b1; load_val = 16'hFFFF; en = 1'b1; u_d = 1'b1;
        step();
        step();
        chk("reset_state", {25'd0, count, fb_word, frame, gray_clk, sat_hi, sat_lo}, 64'h1);
        rst_ext = 1'b0; load = 1'b0;

        for (int k = 0; k < 7; k++) begin
            do_reset();
            u_d = vecs[k].ud;
            if (vecs[k].do_load) begin
                load = 1'b1; load_val = vecs[k].lv; en = vecs[k].en;
                step();
                load = 1'b0;
            end
            en = vecs[k].en;
            repeat (vecs[k].ncyc) step();
            chk($sformatf("vec%0d_count", k), 64'(count), 64'(vecs[k].exp_cnt));
            chk($sformatf("vec%0d_sat_hi", k), 64'(sat_hi), 64'(vecs[k].exp_hi));
            chk($sformatf("vec%0d_sat_lo", k), 64'(sat_lo), 64'(vecs[k].exp_lo));
        end

        // Free-run: frame pulses and single-bit gray steps.
        do_reset();
        ham_bad = 0;
        prev_gc = gray_clk;
        for (int n = 1; n <= 4096; n++) begin
            step();
            if (frame) frames.push_back(n);
            if ($countones(gray_clk ^ prev_gc) > 1) ham_bad++;
            prev_gc = gray_clk;
        end
        chk("frame_count", 64'(frames.size()), 64'd2);
        if (frames.size() == 2) begin
            chk("frame_first", 64'(frames[0]), 64'd2048);
            chk("frame_second", 64'(frames[1]), 64'd4096);
        end
        chk("gray_hamming", 64'(ham_bad), 64'd0);

        // Load coinciding with the capture edge: latch sees the pre-load count.
        do_reset();
        load = 1'b1; load_val = 16'hA5C3;
        step();
        load = 1'b0;
        repeat (2046) step();
        load = 1'b1; load_val = 16'hFFC0;
        step();
        load = 1'b0;
        chk("wrap_fb_preload", 64'(fb_word), 64'h3A5);
        chk("wrap_count_loaded", 64'(count), 64'hFFC0);
        chk("wrap_frame", 64'(frame), 64'd1);
        repeat (2047) step();
        chk("fb_hold_frame", 64'(fb_word), 64'h3A5);
        step();
        chk("fb_next_frame", 64'(fb_word), 64'h3FF);

        // Mid-frame reset restarts prescaler and frame.
        do_reset();
        load = 1'b1; load_val = 16'd500;
        step();
        load = 1'b0;
        repeat (2500) step();
        chk("fb_before_rst", 64'(fb_word), 64'h380);
        rst_ext = 1'b1;
        step();
        chk("midframe_reset", {25'd0, count, fb_word, frame, gray_clk, sat_hi, sat_lo}, 64'h1);
        rst_ext = 1'b0; en = 1'b1; u_d = 1'b1;
        frame_at = 0;
        tick_at = 0;
        for (int n = 1; n <= 3000; n++) begin
            step();
            if (tick_at == 0 && count == 16'd1) tick_at = n;
            if (frame) begin
                frame_at = n;
                break;
            end
        end
        chk("rst_first_frame", 64'(frame_at), 64'd2048);
        chk("rst_first_tick", 64'(tick_at), 64'd16);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fb_count_gen.md
FB_COUNT_GEN -- requirements
Module: fb_count_gen

Interface
REQ-001 Parameter CNT_W, default 16: width of the feedback up/down counter.
REQ-002 Parameter GRAY_W, default 19: width of the free-running gray-code frame counter; GRAY_W SHALL be at least 11.
REQ-003 Parameter CCLK_DIV, default 16: number of clk_ext cycles per counter update tick; CCLK_DIV SHALL be at least 2.
REQ-004 clk_ext  in  1  single clock for all state, rising edge.
REQ-005 rst_ext  in  1  synchronous, active-high reset.
REQ-006 en  in  1  enables counter update ticks; the prescaler and gray counter run regardless of en.
REQ-007 u_d  in  1  direction: 1 = count up, 0 = count down.
REQ-008 load  in  1  synchronous preset strobe.
REQ-009 load_val  in  CNT_W  preset value.
REQ-010 count  out  CNT_W  live counter value.
REQ-011 gray_clk  out  10  gray tap bits gray[10:1], feeding the gray selector clk[9:0].
REQ-012 fb_word  out  10  frame-latched counter MSBs, feeding the gray selector in[9:0].
REQ-013 frame  out  1  one-cycle pulse marking each new gray frame.
REQ-014 sat_hi / sat_lo  out  1 each  counter at all-ones / at zero.

Function
REQ-015 The prescaler SHALL count 0..CCLK_DIV-1 and wrap; tick is true in the cycle where the prescaler equals CCLK_DIV-1.
REQ-016 On tick with en=1, load=0 and u_d=1, count SHALL increment, except that it SHALL hold at 2^CNT_W-1 (saturate, no wrap).
REQ-017 On tick with en=1, load=0 and u_d=0, count SHALL decrement, except that it SHALL hold at 0 (saturate, no wrap).
REQ-018 load=1 SHALL set count to load_val on the next edge, regardless of tick and en, and SHALL NOT reset the prescaler.
REQ-019 A binary frame counter b (GRAY_W bits) SHALL increment every clk_ext cycle and wrap from all-ones to 0.
REQ-020 A registered gray value SHALL follow b ^ (b >> 1), so that exactly one gray bit toggles per cycle; gray_clk = gray[10:1].
REQ-021 On the edge where b wraps to 0, fb_word SHALL capture {count[CNT_W-10], ..., count[CNT_W-1]}, i.e. fb_word[9] = count[CNT_W-10] and fb_word[0] = count[CNT_W-1].
REQ-022 fb_word SHALL hold its value for the whole frame.
REQ-023 frame SHALL be 1 for exactly the cycle in which b == 0.
REQ-024 If a tick or load coincides with the capture edge, fb_word SHALL capture the pre-update count.
REQ-025 sat_hi and sat_lo SHALL be combinational decodes of count.

Reset
REQ-026 While rst_ext=1 at a clock edge, the block SHALL set count=0, prescaler=0, b=0, gray=0, fb_word=0 and frame=0; sat_lo therefore reads 1 and sat_hi reads 0.
REQ-027 Reset SHALL override load and en.
REQ-028 Reset asserted mid-frame SHALL restart the prescaler and the frame from zero on the first cycle after deassertion.
REQ-029 No output SHALL be X after the first reset edge.

Structure
REQ-030 The shared package SHALL hold the default CNT_W, GRAY_W and CCLK_DIV constants and the 10-bit tap-width constant.
REQ-031 The binary-to-gray frame counter SHALL be a single sub-module, fb_gray_frame, with outputs gray and frame; the counter, prescaler and latch remain in fb_count_gen.
REQ-032 fb_count_gen SHALL have no latches, no gated clocks and no asynchronous logic.

Verification (GRAY_W=11, CCLK_DIV=16, CNT_W=16)
REQ-033 Reset, then en=1, u_d=1 for 160 cycles -> count = 10, sat_lo = 0.
REQ-034 load_val=16'hFFFE with load, then en=1, u_d=1 for 64 cycles -> count = FFFF, sat_hi = 1, no wrap.
REQ-035 count=1, u_d=0 for 48 cycles -> count = 0 after the first tick and holds at 0; sat_lo = 1.
REQ-036 Free-run 4096 cycles -> frame pulses at cycles 2048 and 4096 only, and each gray_clk change has Hamming distance <= 1.
REQ-037 load_val=16'hFFC0 on the cycle before a wrap -> fb_word = the pre-load word, and on the next frame fb_word = 10'h3FF.
REQ-038 rst_ext pulse mid-frame with count=500 -> all outputs are reset on the next edge, and the first frame pulse follows 2048 cycles after deassertion.
